pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two and at least 2.
REQ-002 Parameter TAG_W, default 4: width of the user tag carried alongside each operation.
REQ-003 Derived constant SA_W = log2(WIDTH): shift-amount width, and also the pipeline depth.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input operation present.
REQ-007 in_ready  output  1  block can accept an input this cycle.
REQ-008 in_data  input  WIDTH  operand D.
REQ-009 in_shamt  input  SA_W  shift amount s, 0..WIDTH-1.
REQ-010 in_mode  input  2  operation select: 00 logical right, 01 arithmetic right, 10 rotate right, 11 rotate left.
REQ-011 in_tag  input  TAG_W  user tag, passed through unmodified.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  shifted result Q.
REQ-015 out_sticky  output  1  OR of every bit discarded by a right shift; always 0 for rotates.
REQ-016 out_tag  output  TAG_W  tag of the operation currently on the output.

Function
REQ-017 The pipeline SHALL have SA_W register stages; stage k applies a shift of 2^k when in_shamt bit k is 1, and passes data through otherwise.
REQ-018 Each stage SHALL carry:
- valid, data, sticky, mode, tag;
- the shift-amount bits not yet applied.
REQ-019 Advance enable: adv = !out_valid || out_ready; all stages SHALL shift forward together only when adv is 1, and hold otherwise.
REQ-020 Handshake rules:
- in_ready SHALL equal adv, combinationally.
- A transfer occurs when in_valid && in_ready.
- When adv is 1 and in_valid is 0, a bubble (valid=0) SHALL enter stage 0.
REQ-021 Latency:
- An accepted operation SHALL appear on the outputs after exactly SA_W rising edges, counting the accepting edge as the first, provided adv stays 1.
- Throughput SHALL be one operation per cycle.
REQ-022 Logical right SHALL fill vacated MSBs with 0; arithmetic right SHALL fill them with the original in_data[WIDTH-1].
REQ-023 Rotate right and rotate left SHALL be exact circular rotations modulo WIDTH; in_shamt=0 SHALL return in_data unchanged in every mode.
REQ-024 Sticky flag:
- In each right-shift stage, sticky SHALL OR in the bits shifted out.
- The final out_sticky SHALL equal the OR of the in_shamt LSBs of in_data, and 0 when in_shamt=0.
REQ-025 Stall and backpressure:
- While out_valid=1 and out_ready=0, out_data, out_sticky and out_tag SHALL hold stable, and no stage SHALL change.
- in_in fields presented during a stall SHALL NOT be captured.
REQ-026 Ordering: results SHALL leave in acceptance order with their own tags; bubbles SHALL NOT be compressed.
REQ-027 out_valid SHALL depend only on registered state, with no combinational path from in_valid.

Reset
REQ-028 On rst_n low, asynchronously and with no clock:
- every stage valid SHALL clear to 0;
- out_valid SHALL read 0;
- out_data, out_sticky and out_tag SHALL read 0.
REQ-029 Reset in mid-operation SHALL discard every in-flight operation; nothing accepted before reset SHALL appear afterwards.
REQ-030 in_ready SHALL be 1 from the first cycle after rst_n deasserts, since out_valid is 0.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-031 Directed latency check: D=0x0F, s=1, mode 00 accepted at edge t -> out_data=0x07, sticky=1, out_valid asserted after edge t+2.
REQ-032 Directed arithmetic and rotate checks:
- D=0xCC, s=5: mode 01 -> 0xFE sticky=1; mode 10 -> 0x66 sticky=0; mode 11 -> 0x99 sticky=0.
- D=0x0F, s=4, mode 11 -> 0xF0.
REQ-033 Streaming: eight back-to-back operations, D=0x0F with s=0..7 in mode 00, tags 0..7 -> results 0x0F,0x07,0x03,0x01,0x00,0x00,0x00,0x00 on consecutive cycles, in tag order.
REQ-034 Backpressure: drop out_ready with the pipe full for 5 cycles -> in_ready=0 and outputs frozen; on release the outputs resume in order with no loss or duplication.
REQ-035 Reset in flight: assert rst_n low with 3 operations in flight -> out_valid=0 immediately; after release, no stale result emerges.
REQ-036 Random-reference check: parametrised run at WIDTH=32 with random data, shift, mode and stall -> every output matches a behavioural shift model, including sticky.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_if
// Description : Valid/ready operation stream into the barrel shifter and the
//               result stream out of it. The shifter connects as slave and the
//               traffic source/sink as master.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    localparam int SA_W = $clog2(WIDTH);

    // Operation side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SA_W-1:0]  in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_sticky, out_tag
    );

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_sticky, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : log2(WIDTH)-stage barrel shifter. Stage k shifts by 2^k when
//               bit k of the shift amount is set. Supports logical/arithmetic
//               right shift (with sticky of discarded bits) and rotate
//               right/left. The whole pipe advances together under a single
//               enable derived from the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SA_W = $clog2(WIDTH);

    localparam logic [1:0] C_MODE_LSR = 2'b00;
    localparam logic [1:0] C_MODE_ASR = 2'b01;
    localparam logic [1:0] C_MODE_ROR = 2'b10;

    // Per-stage registered state; index SA_W-1 is the output stage.
    logic             r_valid  [SA_W];
    logic [WIDTH-1:0] r_data   [SA_W];
    logic             r_sticky [SA_W];
    logic [1:0]       r_mode   [SA_W];
    logic [TAG_W-1:0] r_tag    [SA_W];
    // Shift-amount bits still to be applied; bit 0 always belongs to the
    // next stage.
    logic [SA_W-1:0]  r_shamt  [SA_W];

    // What each stage sees at its input, and what it will register.
    logic             w_src_valid  [SA_W];
    logic [WIDTH-1:0] w_src_data   [SA_W];
    logic             w_src_sticky [SA_W];
    logic [1:0]       w_src_mode   [SA_W];
    logic [TAG_W-1:0] w_src_tag    [SA_W];
    logic [SA_W-1:0]  w_src_shamt  [SA_W];
    logic [WIDTH-1:0] w_nxt_data   [SA_W];
    logic             w_nxt_sticky [SA_W];

    logic             w_adv;

    // Shift/rotate by a fixed amount. Arithmetic shifts compose across
    // stages because each one replicates the current MSB, which stays equal
    // to the original sign bit.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int unsigned      sh
    );
        case (m)
            C_MODE_LSR: f_shift = d >> sh;
            C_MODE_ASR: f_shift = $unsigned($signed(d) >>> sh);
            C_MODE_ROR: f_shift = (d >> sh) | (d << (WIDTH - sh));
            default:    f_shift = (d << sh) | (d >> (WIDTH - sh));
        endcase
    endfunction

    // Any 1 among the low sh bits that a right shift drops; rotates lose
    // nothing.
    function automatic logic f_lost(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int unsigned      sh
    );
        logic [WIDTH-1:0] mask;
        mask   = ~({WIDTH{1'b1}} << sh);
        f_lost = !m[1] && (|(d & mask));
    endfunction

    // The pipe moves only when the output slot is empty or being drained.
    assign w_adv        = !r_valid[SA_W-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < SA_W; k++) begin : g_stage
        localparam int unsigned SH = 1 << k;

        if (k == 0) begin : g_head
            assign w_src_valid[k]  = bus.in_valid;
            assign w_src_data[k]   = bus.in_data;
            assign w_src_sticky[k] = 1'b0;
            assign w_src_mode[k]   = bus.in_mode;
            assign w_src_tag[k]    = bus.in_tag;
            assign w_src_shamt[k]  = bus.in_shamt;
        end else begin : g_body
            assign w_src_valid[k]  = r_valid[k-1];
            assign w_src_data[k]   = r_data[k-1];
            assign w_src_sticky[k] = r_sticky[k-1];
            assign w_src_mode[k]   = r_mode[k-1];
            assign w_src_tag[k]    = r_tag[k-1];
            assign w_src_shamt[k]  = r_shamt[k-1];
        end

        assign w_nxt_data[k]   = w_src_shamt[k][0]
                               ? f_shift(w_src_data[k], w_src_mode[k], SH)
                               : w_src_data[k];
        assign w_nxt_sticky[k] = w_src_sticky[k]
                               | (w_src_shamt[k][0]
                                  & f_lost(w_src_data[k], w_src_mode[k], SH));
    end

    // Advance every stage together on w_adv; a missing input becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SA_W; k++) begin
                r_valid[k]  <= 1'b0;
                r_data[k]   <= '0;
                r_sticky[k] <= 1'b0;
                r_mode[k]   <= '0;
                r_tag[k]    <= '0;
                r_shamt[k]  <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < SA_W; k++) begin
                r_valid[k]  <= w_src_valid[k];
                r_data[k]   <= w_nxt_data[k];
                r_sticky[k] <= w_nxt_sticky[k];
                r_mode[k]   <= w_src_mode[k];
                r_tag[k]    <= w_src_tag[k];
                r_shamt[k]  <= w_src_shamt[k] >> 1;
            end
        end
    end

    assign bus.out_valid  = r_valid[SA_W-1];
    assign bus.out_data   = r_data[SA_W-1];
    assign bus.out_sticky = r_sticky[SA_W-1];
    assign bus.out_tag    = r_tag[SA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Self-checking bench. Directed checks on an 8-bit instance and
//               a randomized, stall-heavy run on a 32-bit instance, both
//               scored against an arithmetic shift model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(8),  .TAG_W(4)) b8  ();
    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(4)) b32 ();

    pipelined_barrel_shifter #(.WIDTH(8),  .TAG_W(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    typedef struct packed {
        logic [31:0] d;
        logic        st;
        logic [3:0]  tg;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    bit   prev_stall = 1'b0;
    logic [7:0] sd [8] = '{8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word shift of width w by s using plain arithmetic.
    function automatic exp_t model(input int w, input logic [31:0] d, input int s,
                                   input int m, input logic [3:0] tg);
        logic [63:0] mask, dd, r;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        dd   = {32'd0, d} & mask;
        case (m)
            0:       r = dd >> s;
            1:       r = (dd >> s) | (dd[w-1] ? (mask & ~(mask >> s)) : 64'd0);
            2:       r = ((dd >> s) | (dd << (w - s))) & mask;
            default: r = ((dd << s) | (dd >> (w - s))) & mask;
        endcase
        e.d  = r[31:0];
        e.st = (m < 2) && ((dd & ((64'd1 << s) - 64'd1)) != 64'd0);
        e.tg = tg;
        return e;
    endfunction

    task automatic drive(input bit w32, input bit v, input logic [31:0] d, input int s,
                         input int m, input logic [3:0] tg, input bit ordy);
        if (w32) begin
            b32.in_valid = v;  b32.in_data = d;        b32.in_shamt = 5'(s);
            b32.in_mode  = 2'(m); b32.in_tag = tg;     b32.out_ready = ordy;
        end else begin
            b8.in_valid  = v;  b8.in_data  = d[7:0];   b8.in_shamt  = 3'(s);
            b8.in_mode   = 2'(m); b8.in_tag  = tg;     b8.out_ready  = ordy;
        end
    endtask

    // One clock of scoreboarded traffic: evaluate the pending handshakes
    // mid-cycle, then let the edge happen.
    task automatic step(input bit w32);
        logic iv, ir, ov, ordy, ost;
        logic [31:0] id, od;
        logic [3:0] itg, otg;
        int ish, imd;
        exp_t e;
        @(negedge clk);
        if (w32) begin
            iv = b32.in_valid; ir = b32.in_ready; id = b32.in_data;
            ish = int'(b32.in_shamt); imd = int'(b32.in_mode); itg = b32.in_tag;
            ov = b32.out_valid; ordy = b32.out_ready; od = b32.out_data;
            ost = b32.out_sticky; otg = b32.out_tag;
        end else begin
            iv = b8.in_valid; ir = b8.in_ready; id = {24'd0, b8.in_data};
            ish = int'(b8.in_shamt); imd = int'(b8.in_mode); itg = b8.in_tag;
            ov = b8.out_valid; ordy = b8.out_ready; od = {24'd0, b8.out_data};
            ost = b8.out_sticky; otg = b8.out_tag;
        end
        chk("in_ready", 64'(ir), 64'(!ov || ordy));
        if (prev_stall) chk("stall_valid", 64'(ov), 64'd1);
        if (ov) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(ov), 64'd0);
            end else begin
                chk("out_result", 64'({od, ost, otg}), 64'({q[0].d, q[0].st, q[0].tg}));
                if (ordy) e = q.pop_front();
            end
        end
        if (iv && ir) q.push_back(model(w32 ? 32 : 8, id, ish, imd, itg));
        prev_stall = ov && !ordy;
        @(posedge clk);
        #1;
    endtask

    // Single 8-bit operation with a bounded wait for its result.
    task automatic one8(input string tag, input logic [7:0] d, input int s, input int m,
                        input logic [7:0] xd, input bit xs);
        int n = 0;
        drive(0, 1'b1, {24'd0, d}, s, m, 4'hA, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
        while (b8.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'({b8.out_valid, b8.out_data, b8.out_sticky, b8.out_tag}),
            64'({1'b1, xd, xs, 4'hA}));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
        drive(1, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);

        // Reset state, before any clock edge
        #3;
        chk("rst_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_outs",  64'({b8.out_data, b8.out_sticky, b8.out_tag}), 64'd0);
        chk("rst_valid32", 64'(b32.out_valid), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(b8.in_ready), 64'd1);

        // Latency: accepted at edge t, visible after edge t+2
        drive(0, 1'b1, 32'h0F, 1, 0, 4'h5, 1'b1);
        @(posedge clk); #1;
        chk("lat_t0", 64'(b8.out_valid), 64'd0);
        drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
        @(posedge clk); #1;
        chk("lat_t1", 64'(b8.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_t2", 64'({b8.out_valid, b8.out_data, b8.out_sticky, b8.out_tag}),
            64'({1'b1, 8'h07, 1'b1, 4'h5}));
        @(posedge clk); #1;
        chk("lat_drain", 64'(b8.out_valid), 64'd0);

        // Directed arithmetic / rotate / boundary cases
        one8("asr_cc_5", 8'hCC, 5, 1, 8'hFE, 1'b1);
        one8("ror_cc_5", 8'hCC, 5, 2, 8'h66, 1'b0);
        one8("rol_cc_5", 8'hCC, 5, 3, 8'h99, 1'b0);
        one8("rol_0f_4", 8'h0F, 4, 3, 8'hF0, 1'b0);
        one8("asr_80_0", 8'h80, 0, 1, 8'h80, 1'b0);
        one8("lsr_ff_7", 8'hFF, 7, 0, 8'h01, 1'b1);
        one8("ror_81_0", 8'h81, 0, 2, 8'h81, 1'b0);

        // Streaming: eight back-to-back ops, results on consecutive cycles
        for (int j = 0; j < 12; j++) begin
            if (j < 8) drive(0, 1'b1, 32'h0F, j, 0, 4'(j), 1'b1);
            else       drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
            @(negedge clk);
            if (j >= 3 && j < 11)
                chk("stream", 64'({b8.out_valid, b8.out_data, b8.out_sticky, b8.out_tag}),
                    64'({1'b1, sd[j-3], (j - 3) != 0, 4'(j - 3)}));
            else
                chk("stream_idle", 64'(b8.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Backpressure with a full pipe
        prev_stall = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(0, 1'b1, $urandom, $urandom_range(0, 7), $urandom_range(0, 3), 4'(j), 1'b1);
            step(0);
        end
        for (int j = 0; j < 5; j++) begin
            drive(0, 1'b1, $urandom, $urandom_range(0, 7), $urandom_range(0, 3), 4'(8 + j), 1'b0);
            step(0);
            chk("bp_in_ready", 64'(b8.in_ready), 64'd0);
        end
        for (int j = 0; j < 6; j++) begin
            drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
            step(0);
        end
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Reset with three operations in flight
        for (int j = 0; j < 3; j++) begin
            drive(0, 1'b1, $urandom, $urandom_range(1, 7), $urandom_range(0, 3), 4'(j), 1'b1);
            step(0);
        end
        drive(0, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
        chk("rif_busy", 64'(b8.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rif_valid", 64'(b8.out_valid), 64'd0);
        chk("rif_outs", 64'({b8.out_data, b8.out_sticky, b8.out_tag}), 64'd0);
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) step(0);

        // Randomized run on the 32-bit instance with random stalls
        prev_stall = 1'b0;
        for (int j = 0; j < 400; j++) begin
            drive(1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 31),
                  $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 3) != 0);
            step(1);
        end
        for (int j = 0; j < 10; j++) begin
            drive(1, 1'b0, 32'd0, 0, 0, 4'h0, 1'b1);
            step(1);
        end
        chk("rnd_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
